// File: rtl/regfile_read_seq_if.sv
// -----------------------------------------------------------------------------
// regfile_read_seq_if
//
// Purpose: bundles every non-clock/reset signal of regfile_read_seq into one
// interface so the sequencer, its producer, the register file and the
// consumer all share a single connection point.
//
// Signal groups:
//   request   : in_valid / in_ready, src_addr0..3, src_en
//   rf read   : rf_raddr_a/b (to RF), rf_rdata_a/b (combinational from RF)
//   bypass    : wr1_en/addr/data, wr2_en/addr/data (RF write ports, watched)
//   response  : out_valid / out_ready, op0..op3
//
// Modports:
//   slave  - the sequencer's view (drives in_ready, rf_raddr_*, out_valid, ops)
//   master - the surrounding logic's view (everything else)
// -----------------------------------------------------------------------------
interface regfile_read_seq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] src_addr0;
    logic [ADDR_W-1:0] src_addr1;
    logic [ADDR_W-1:0] src_addr2;
    logic [ADDR_W-1:0] src_addr3;
    logic [3:0]        src_en;

    logic [ADDR_W-1:0] rf_raddr_a;
    logic [ADDR_W-1:0] rf_raddr_b;
    logic [DATA_W-1:0] rf_rdata_a;
    logic [DATA_W-1:0] rf_rdata_b;

    logic              wr1_en;
    logic [ADDR_W-1:0] wr1_addr;
    logic [DATA_W-1:0] wr1_data;
    logic              wr2_en;
    logic [ADDR_W-1:0] wr2_addr;
    logic [DATA_W-1:0] wr2_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] op0;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] op3;

    modport slave (
        input  in_valid, src_addr0, src_addr1, src_addr2, src_addr3, src_en,
        input  rf_rdata_a, rf_rdata_b,
        input  wr1_en, wr1_addr, wr1_data, wr2_en, wr2_addr, wr2_data,
        input  out_ready,
        output in_ready, rf_raddr_a, rf_raddr_b,
        output out_valid, op0, op1, op2, op3
    );

    modport master (
        output in_valid, src_addr0, src_addr1, src_addr2, src_addr3, src_en,
        output rf_rdata_a, rf_rdata_b,
        output wr1_en, wr1_addr, wr1_data, wr2_en, wr2_addr, wr2_data,
        output out_ready,
        input  in_ready, rf_raddr_a, rf_raddr_b,
        input  out_valid, op0, op1, op2, op3
    );
endinterface

// File: rtl/regfile_read_seq.sv
// -----------------------------------------------------------------------------
// regfile_read_seq
//
// Purpose: reads up to four source operands through a two-port register file.
// Operands 0/1 are read in RD_LO, operands 2/3 in RD_HI (skipped when neither
// is enabled). Each read is bypassed from the two RF write ports (wr2 wins
// over wr1, both win over the RF array) and snapshotted into output flops,
// which are presented with a valid/ready handshake from DONE.
//
// Ports:
//   clk   - single clock, all state changes on posedge
//   reset - asynchronous, active-high; returns to IDLE and clears all state
//   bus   - regfile_read_seq_if.slave (request, RF read, bypass, response)
//
// Latency: bundle accepted in cycle T -> out_valid in T+2 (ops 2/3 disabled)
// or T+3 (otherwise). DONE with out_ready and in_valid re-accepts directly.
// -----------------------------------------------------------------------------
module regfile_read_seq #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    regfile_read_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_LO = 2'd1,
        RD_HI = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q [4];
    logic [ADDR_W-1:0] addr_d [4];
    logic [3:0]        en_q, en_d;
    logic [DATA_W-1:0] op_q [4];
    logic [DATA_W-1:0] op_d [4];
    logic              out_valid_q, out_valid_d;

    logic [ADDR_W-1:0] src_addr [4];
    logic [ADDR_W-1:0] raddr [2];
    logic [DATA_W-1:0] rdata [2];
    logic [DATA_W-1:0] fwd_data [2];
    logic              in_ready;
    logic              accept;

    assign src_addr[0] = bus.src_addr0;
    assign src_addr[1] = bus.src_addr1;
    assign src_addr[2] = bus.src_addr2;
    assign src_addr[3] = bus.src_addr3;

    assign rdata[0] = bus.rf_rdata_a;
    assign rdata[1] = bus.rf_rdata_b;

    assign bus.rf_raddr_a = raddr[0];
    assign bus.rf_raddr_b = raddr[1];

    assign in_ready      = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
    assign accept        = bus.in_valid & in_ready;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.op0       = op_q[0];
    assign bus.op1       = op_q[1];
    assign bus.op2       = op_q[2];
    assign bus.op3       = op_q[3];

    // Read addresses depend only on registered state, kept apart from the
    // next-state block so the bypass path below is not a combinational loop.
    always_comb begin
        raddr[0] = '0;
        raddr[1] = '0;
        case (state_q)
            RD_LO: begin
                raddr[0] = addr_q[0];
                raddr[1] = addr_q[1];
            end
            RD_HI: begin
                raddr[0] = addr_q[2];
                raddr[1] = addr_q[3];
            end
            default: begin
                raddr[0] = '0;
                raddr[1] = '0;
            end
        endcase
    end

    // Per read port: a write landing this very edge is newer than the RF
    // contents, and wr2 is the later of the two writers.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_data[gi] =
                (bus.wr2_en && (bus.wr2_addr == raddr[gi])) ? bus.wr2_data :
                (bus.wr1_en && (bus.wr1_addr == raddr[gi])) ? bus.wr1_data :
                                                              rdata[gi];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        out_valid_d = out_valid_q;
        for (int i = 0; i < 4; i++) begin
            addr_d[i] = addr_q[i];
            op_d[i]   = op_q[i];
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RD_LO;
                end
            end
            RD_LO: begin
                op_d[0] = en_q[0] ? fwd_data[0] : '0;
                op_d[1] = en_q[1] ? fwd_data[1] : '0;
                // Cleared here so a skipped RD_HI still presents zeros.
                op_d[2] = '0;
                op_d[3] = '0;
                if (en_q[3:2] != 2'b00) begin
                    state_d = RD_HI;
                end else begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            RD_HI: begin
                op_d[2]     = en_q[2] ? fwd_data[0] : '0;
                op_d[3]     = en_q[3] ? fwd_data[1] : '0;
                state_d     = DONE;
                out_valid_d = 1'b1;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = bus.in_valid ? RD_LO : IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        // accept is only possible in IDLE or in DONE with out_ready.
        if (accept) begin
            en_d = bus.src_en;
            for (int i = 0; i < 4; i++) begin
                addr_d[i] = src_addr[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            en_q        <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                addr_q[i] <= '0;
                op_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < 4; i++) begin
                addr_q[i] <= addr_d[i];
                op_q[i]   <= op_d[i];
            end
        end
    end
endmodule

// File: tb/tb_regfile_read_seq.sv
// -----------------------------------------------------------------------------
// tb_regfile_read_seq
//
// Directed bench for regfile_read_seq. A register-file array inside the bench
// serves the read ports and absorbs the wr1/wr2 writes. A transaction model
// (one outstanding bundle: when accepted, which cycle each operand pair is
// sampled, when it must become valid) is compared against the DUT on every
// falling edge; the stimulus process adds literal expectations per scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_read_seq;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 2 ** ADDR_W;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    regfile_read_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_read_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- register file seen by the DUT ----------------
    logic [DATA_W-1:0] rf [NREG];

    always @(posedge clk) begin
        if (bus.wr1_en) rf[bus.wr1_addr] <= bus.wr1_data;
        if (bus.wr2_en) rf[bus.wr2_addr] <= bus.wr2_data;
    end

    assign bus.rf_rdata_a = rf[bus.rf_raddr_a];
    assign bus.rf_rdata_b = rf[bus.rf_raddr_b];

    logic [DATA_W-1:0] dut_op [4];
    assign dut_op[0] = bus.op0;
    assign dut_op[1] = bus.op1;
    assign dut_op[2] = bus.op2;
    assign dut_op[3] = bus.op3;

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Value the register at address a holds once this edge's writes land.
    function automatic logic [DATA_W-1:0] newest(input logic [ADDR_W-1:0] a);
        if (bus.wr2_en && bus.wr2_addr == a) return bus.wr2_data;
        if (bus.wr1_en && bus.wr1_addr == a) return bus.wr1_data;
        return rf[a];
    endfunction

    // ---------------- transaction model + per-cycle compare ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit                m_pend = 1'b0;
    int                m_acc;
    int                m_rdy;
    logic [ADDR_W-1:0] m_addr [4];
    logic [3:0]        m_en;
    logic [DATA_W-1:0] m_op [4];
    int                n_txn = 0;

    always @(negedge clk) begin
        logic              exp_ov;
        logic              exp_ir;
        logic [ADDR_W-1:0] ea;
        logic [ADDR_W-1:0] eb;
        if (reset) begin
            m_pend = 1'b0;
            check("rst_in_ready", bus.in_ready, 1'b1);
            check("rst_out_valid", bus.out_valid, 1'b0);
            check("rst_raddr_a", bus.rf_raddr_a, '0);
            check("rst_raddr_b", bus.rf_raddr_b, '0);
            for (int i = 0; i < 4; i++) check("rst_op", dut_op[i], '0);
        end else begin
            exp_ov = m_pend && (cyc >= m_rdy);
            exp_ir = !m_pend || (exp_ov && bus.out_ready);
            ea = '0;
            eb = '0;
            if (m_pend && cyc == m_acc + 1) begin
                ea = m_addr[0];
                eb = m_addr[1];
                m_op[0] = m_en[0] ? newest(m_addr[0]) : '0;
                m_op[1] = m_en[1] ? newest(m_addr[1]) : '0;
            end
            if (m_pend && m_en[3:2] != 2'b00 && cyc == m_acc + 2) begin
                ea = m_addr[2];
                eb = m_addr[3];
                m_op[2] = m_en[2] ? newest(m_addr[2]) : '0;
                m_op[3] = m_en[3] ? newest(m_addr[3]) : '0;
            end
            check("out_valid", bus.out_valid, exp_ov);
            check("in_ready", bus.in_ready, exp_ir);
            check("rf_raddr_a", bus.rf_raddr_a, ea);
            check("rf_raddr_b", bus.rf_raddr_b, eb);
            if (exp_ov) begin
                for (int i = 0; i < 4; i++) check("op_model", dut_op[i], m_op[i]);
            end
            if (exp_ov && bus.out_ready) begin
                n_txn++;
                $display("txn %0d: en=%b addrs=%0d,%0d,%0d,%0d ops=0x%0h,0x%0h,0x%0h,0x%0h latency=%0d",
                         n_txn, m_en, m_addr[0], m_addr[1], m_addr[2], m_addr[3],
                         dut_op[0], dut_op[1], dut_op[2], dut_op[3], m_rdy - m_acc);
                m_pend = 1'b0;
            end
            if (exp_ir && bus.in_valid) begin
                m_pend    = 1'b1;
                m_acc     = cyc;
                m_en      = bus.src_en;
                m_addr[0] = bus.src_addr0;
                m_addr[1] = bus.src_addr1;
                m_addr[2] = bus.src_addr2;
                m_addr[3] = bus.src_addr3;
                for (int i = 0; i < 4; i++) m_op[i] = '0;
                m_rdy = cyc + ((bus.src_en[3:2] != 2'b00) ? 3 : 2);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int a0, input int a1, input int a2, input int a3, input logic [3:0] en);
        bus.in_valid  = 1'b1;
        bus.src_addr0 = ADDR_W'(a0);
        bus.src_addr1 = ADDR_W'(a1);
        bus.src_addr2 = ADDR_W'(a2);
        bus.src_addr3 = ADDR_W'(a3);
        bus.src_en    = en;
    endtask

    // Presents a bundle in the current (idle) cycle; returns in the cycle after.
    task automatic send(input int a0, input int a1, input int a2, input int a3, input logic [3:0] en);
        set_req(a0, a1, a2, a3, en);
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Called in the cycle after acceptance; lat counts cycles from acceptance.
    task automatic wait_ov(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_ops(input string name, input int e0, input int e1, input int e2, input int e3);
        check({name, "_op0"}, bus.op0, DATA_W'(e0));
        check({name, "_op1"}, bus.op1, DATA_W'(e1));
        check({name, "_op2"}, bus.op2, DATA_W'(e2));
        check({name, "_op3"}, bus.op3, DATA_W'(e3));
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.src_addr0 = '0;
        bus.src_addr1 = '0;
        bus.src_addr2 = '0;
        bus.src_addr3 = '0;
        bus.src_en    = '0;
        bus.wr1_en    = 1'b0;
        bus.wr1_addr  = '0;
        bus.wr1_data  = '0;
        bus.wr2_en    = 1'b0;
        bus.wr2_addr  = '0;
        bus.wr2_data  = '0;
        bus.out_ready = 1'b1;

        // Reset held, then released.
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", bus.in_ready, 1'b1);
        check("reset_out_valid", bus.out_valid, 1'b0);
        reset = 1'b0;
        check("release_in_ready", bus.in_ready, 1'b1);
        check("release_raddr_a", bus.rf_raddr_a, '0);

        // Preload r1..r6 = 11*i, r7 = 0xC through write port 1.
        for (int i = 1; i <= 7; i++) begin
            bus.wr1_en   = 1'b1;
            bus.wr1_addr = ADDR_W'(i);
            bus.wr1_data = (i == 7) ? DATA_W'(32'hC) : DATA_W'(i * 11);
            tick();
        end
        bus.wr1_en = 1'b0;
        tick();

        // Full bundle: four operands, ready three cycles after acceptance.
        send(1, 2, 3, 4, 4'b1111);
        check("full_rd_lo_addr_a", bus.rf_raddr_a, ADDR_W'(1));
        wait_ov(lat);
        check("full_latency", lat, 3);
        check_ops("full", 11, 22, 33, 44);
        tick();

        // Short bundle: upper operands disabled, RD_HI skipped, upper ops zero.
        send(5, 6, 1, 2, 4'b0011);
        check("short_rd_lo_addr_b", bus.rf_raddr_b, ADDR_W'(6));
        wait_ov(lat);
        check("short_latency", lat, 2);
        check_ops("short", 55, 66, 0, 0);
        tick();

        // Bypass: both writers hit addr0 during its read cycle -> wr2 wins.
        // op1 also hits r7 but is disabled, so it must read as zero.
        send(7, 7, 0, 0, 4'b0001);
        bus.wr1_en = 1'b1; bus.wr1_addr = ADDR_W'(7); bus.wr1_data = DATA_W'(32'hA);
        bus.wr2_en = 1'b1; bus.wr2_addr = ADDR_W'(7); bus.wr2_data = DATA_W'(32'hB);
        tick();
        bus.wr1_en = 1'b0;
        bus.wr2_en = 1'b0;
        check("byp_both_valid", bus.out_valid, 1'b1);
        check_ops("byp_both", 32'hB, 0, 0, 0);
        tick();

        // Bypass: wr1 alone.
        send(7, 0, 0, 0, 4'b0001);
        bus.wr1_en = 1'b1; bus.wr1_addr = ADDR_W'(7); bus.wr1_data = DATA_W'(32'hA);
        tick();
        bus.wr1_en = 1'b0;
        check_ops("byp_wr1", 32'hA, 0, 0, 0);
        tick();

        // Backpressure: hold DONE, then overwrite two source registers.
        bus.out_ready = 1'b0;
        send(1, 2, 3, 4, 4'b1111);
        wait_ov(lat);
        check("bp_latency", lat, 3);
        repeat (5) tick();
        check("bp_hold_valid", bus.out_valid, 1'b1);
        check("bp_hold_in_ready", bus.in_ready, 1'b0);
        bus.wr1_en = 1'b1; bus.wr1_addr = ADDR_W'(1); bus.wr1_data = DATA_W'(32'h99);
        bus.wr2_en = 1'b1; bus.wr2_addr = ADDR_W'(3); bus.wr2_data = DATA_W'(32'h77);
        tick();
        bus.wr1_en = 1'b0;
        bus.wr2_en = 1'b0;
        tick();
        check("bp_after_wr_valid", bus.out_valid, 1'b1);
        check("bp_after_wr_in_ready", bus.in_ready, 1'b0);
        check_ops("bp_snapshot", 11, 22, 33, 44);

        // Back-to-back: release and present a new bundle in the same DONE cycle.
        bus.out_ready = 1'b1;
        set_req(5, 6, 0, 0, 4'b0011);
        #1;
        check("b2b_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("b2b_no_bubble_valid", bus.out_valid, 1'b0);
        check("b2b_no_bubble_raddr_a", bus.rf_raddr_a, ADDR_W'(5));
        check("b2b_no_bubble_raddr_b", bus.rf_raddr_b, ADDR_W'(6));
        wait_ov(lat);
        check("b2b_latency", lat, 2);
        check_ops("b2b", 55, 66, 0, 0);
        tick();

        // Reset mid-operation (in RD_HI, op0/op1 already captured as 0x99/22).
        send(1, 2, 3, 4, 4'b1111);
        tick();
        check("midrst_rd_hi_addr_a", bus.rf_raddr_a, ADDR_W'(3));
        #1;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check_ops("midrst", 0, 0, 0, 0);
        check("midrst_in_ready", bus.in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_release_in_ready", bus.in_ready, 1'b1);
        check("midrst_release_raddr_b", bus.rf_raddr_b, '0);
        repeat (4) begin
            tick();
            check("midrst_discarded", bus.out_valid, 1'b0);
        end

        // Recovery after reset.
        send(5, 6, 0, 0, 4'b0011);
        wait_ov(lat);
        check("recover_latency", lat, 2);
        check_ops("recover", 55, 66, 0, 0);
        tick();
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
